// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and FSM-state definitions for the ALU command sequencer.
// Imported by the sequencer top and its command FIFO.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_MUL = 4'b0010,
    OP_DIV = 4'b0011,
    OP_MOD = 4'b0100,
    OP_AND = 4'b0101,
    OP_OR  = 4'b0110,
    OP_XOR = 4'b0111,
    OP_SHL = 4'b1000,
    OP_SHR = 4'b1001
  } opcode_e;

  // Highest legal opcode; anything above is reported as an error response.
  localparam logic [3:0] OP_LAST = OP_SHR;

  // Bit positions inside rsp_flags = {of, carry, cero, neg}.
  localparam int unsigned FLAG_OF    = 3;
  localparam int unsigned FLAG_CARRY = 2;
  localparam int unsigned FLAG_CERO  = 1;
  localparam int unsigned FLAG_NEG   = 0;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StResp
  } state_e;

  function automatic logic op_legal(input logic [3:0] sel);
    return sel <= OP_LAST;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for the ALU sequencer: DEPTH entries, first-word fall-through read port.
// Push is ignored when full, pop is ignored when empty.
module alu_cmd_fifo #(
  parameter int unsigned DW    = 12,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          pop_i,
  output logic [DW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]   wptr_q, rptr_q;
  logic          do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wptr_q[AW-1:0]] <= wdata_i;
        wptr_q                <= wptr_q + {{AW{1'b0}}, 1'b1};
      end
      if (do_pop) begin
        rptr_q <= rptr_q + {{AW{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Initiator-side controller for the combinational ALU: queues commands, issues them to the
// ALU ports, and holds the captured result/flags in a response register until accepted.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_sel,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_of,
  input  logic             alu_carry,
  input  logic             alu_cero,
  input  logic             alu_neg,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  output logic             rsp_err,
  output logic [CNT_W-1:0] op_count
);

  localparam int unsigned EntryW = 4 + 2 * WIDTH;

  state_e            state_q;
  logic              fifo_full, fifo_empty, fifo_pop;
  logic [EntryW-1:0] fifo_rdata;
  logic [3:0]        head_sel;
  logic [WIDTH-1:0]  head_a, head_b;

  assign cmd_ready = !fifo_full;
  assign fifo_pop  = (state_q == StIdle) && !fifo_empty;
  assign {head_sel, head_a, head_b} = fifo_rdata;

  alu_cmd_fifo #(
    .DW    (EntryW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (cmd_valid),
    .wdata_i ({cmd_sel, cmd_a, cmd_b}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
      op_count   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            if (op_legal(head_sel)) begin
              alu_a   <= head_a;
              alu_b   <= head_b;
              alu_sel <= head_sel;
              state_q <= StIssue;
            end else begin
              // Illegal opcodes never reach the ALU; its ports keep the last legal command.
              rsp_err    <= 1'b1;
              rsp_result <= '0;
              rsp_flags  <= '0;
              rsp_valid  <= 1'b1;
              state_q    <= StResp;
            end
          end
        end
        StIssue: begin
          rsp_result            <= alu_result;
          rsp_flags[FLAG_OF]    <= alu_of;
          rsp_flags[FLAG_CARRY] <= alu_carry;
          rsp_flags[FLAG_CERO]  <= alu_cero;
          rsp_flags[FLAG_NEG]   <= alu_neg;
          rsp_err               <= 1'b0;
          rsp_valid             <= 1'b1;
          state_q               <= StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + {{(CNT_W-1){1'b0}}, 1'b1};
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: behavioural 4-bit ALU behind the DUT, directed scenarios, then
// randomized traffic checked against an in-order command queue model.
module tb_alu_cmd_sequencer;

  typedef struct packed {
    logic [3:0] sel;
    logic [3:0] a;
    logic [3:0] b;
  } cmd_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_sel = '0, cmd_a = '0, cmd_b = '0;
  logic [3:0] alu_a, alu_b, alu_sel, alu_result;
  logic       alu_of, alu_carry, alu_cero, alu_neg;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [3:0] rsp_result, rsp_flags;
  logic       rsp_err;
  logic [7:0] op_count;

  int   vectors = 0;
  int   miscompares = 0;
  cmd_t exp_q[$];
  cmd_t last_legal = '0;
  logic [7:0] model_cnt = '0;

  always #5 clk = ~clk;

  // {of, carry, cero, neg, result} from plain integer arithmetic.
  function automatic logic [7:0] alu_f(input logic [3:0] sel, input logic [3:0] a,
                                       input logic [3:0] b);
    int ua, ub, sa, sb, sr, r;
    logic of, cy;
    ua = int'(a);
    ub = int'(b);
    sa = a[3] ? ua - 16 : ua;
    sb = b[3] ? ub - 16 : ub;
    of = 1'b0;
    cy = 1'b0;
    r  = 0;
    case (sel)
      4'd0: begin r = ua + ub; cy = r > 15; sr = sa + sb; of = sr > 7 || sr < -8; end
      4'd1: begin r = ua - ub; cy = ua < ub; sr = sa - sb; of = sr > 7 || sr < -8; end
      4'd2: begin r = ua * ub; cy = r > 15; end
      4'd3: if (ub == 0) of = 1'b1; else r = ua / ub;
      4'd4: if (ub == 0) of = 1'b1; else r = ua % ub;
      4'd5: r = ua & ub;
      4'd6: r = ua | ub;
      4'd7: r = ua ^ ub;
      4'd8: begin r = ua * 2; cy = a[3]; end
      4'd9: begin r = ua / 2; cy = a[0]; end
      default: r = 0;
    endcase
    r = r & 15;
    return {of, cy, r == 0, r >= 8, r[3:0]};
  endfunction

  always_comb begin
    {alu_of, alu_carry, alu_cero, alu_neg, alu_result} = alu_f(alu_sel, alu_a, alu_b);
  end

  alu_cmd_sequencer #(
    .WIDTH (4),
    .DEPTH (4),
    .CNT_W (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_sel    (cmd_sel),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .alu_of     (alu_of),
    .alu_carry  (alu_carry),
    .alu_cero   (alu_cero),
    .alu_neg    (alu_neg),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .rsp_err    (rsp_err),
    .op_count   (op_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs only change just after posedge, so negedge values are what the next edge sees.
  always @(negedge clk) begin
    if (rst_n && cmd_valid && cmd_ready) exp_q.push_back('{sel: cmd_sel, a: cmd_a, b: cmd_b});
    if (rst_n && rsp_valid && rsp_ready) begin
      chk("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        cmd_t c;
        logic legal;
        logic [7:0] r;
        c     = exp_q.pop_front();
        legal = c.sel <= 4'd9;
        r     = legal ? alu_f(c.sel, c.a, c.b) : 8'h00;
        if (legal) last_legal = c;
        chk("rsp_err", 32'(rsp_err), 32'(!legal));
        chk("rsp_result", 32'(rsp_result), 32'(r[3:0]));
        chk("rsp_flags", 32'(rsp_flags), 32'(r[7:4]));
        chk("alu_ports", 32'({alu_sel, alu_a, alu_b}), 32'(last_legal));
        model_cnt = model_cnt + 8'd1;
      end
    end
  end

  task automatic push(input logic [3:0] sel, input logic [3:0] a, input logic [3:0] b);
    bit ok;
    cmd_valid = 1'b1;
    cmd_sel   = sel;
    cmd_a     = a;
    cmd_b     = b;
    ok        = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = cmd_ready;
      @(posedge clk);
      #1;
    end
    chk("push_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 20 && rsp_valid !== 1'b1; i++) @(negedge clk);
    chk("rsp_timeout", 32'(rsp_valid), 32'd1);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && !rsp_valid;
    end
    chk("drain", 32'(done), 32'd1);
    chk("op_count", 32'(op_count), 32'(model_cnt));
  endtask

  initial begin
    int pushes;
    int cycles;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_result", 32'(rsp_result), 32'd0);
    chk("rst_rsp_flags", 32'(rsp_flags), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    chk("rst_alu", 32'({alu_sel, alu_a, alu_b}), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // ADD 3+4: ALU ports one edge after push, response two edges after push
    @(posedge clk);
    #1;
    push(4'h0, 4'h3, 4'h4);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("lat_early_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("lat_alu_ports", 32'({alu_sel, alu_a, alu_b}), 32'h034);
    chk("lat_issue_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("lat_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("add_result", 32'(rsp_result), 32'h7);
    chk("add_flags", 32'(rsp_flags), 32'h0);
    chk("add_err", 32'(rsp_err), 32'd0);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("add_op_count", 32'(op_count), 32'd1);

    // Five back-to-back pushes with consumer stalled: four stored, one in flight
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) push(4'(i), 4'(i + 1), 4'(9 - i));
    cmd_sel = 4'h0;
    cmd_a   = 4'hF;
    cmd_b   = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    drain();
    chk("five_op_count", 32'(op_count), 32'd6);

    // Illegal opcode followed by a legal one
    @(posedge clk);
    #1;
    push(4'hC, 4'h5, 4'h6);
    push(4'h7, 4'hA, 4'h3);
    cmd_valid = 1'b0;
    drain();

    // SUB 2-5 held by a stalled consumer for ten cycles
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    push(4'h1, 4'h2, 4'h5);
    cmd_valid = 1'b0;
    wait_rsp();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_result", 32'(rsp_result), 32'hD);
      chk("hold_flags", 32'(rsp_flags), 32'b0101);
      chk("hold_alu_sel", 32'(alu_sel), 32'h1);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    drain();

    // Reset while a response is held and two commands are queued
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    push(4'h2, 4'h3, 4'h3);
    push(4'h5, 4'hC, 4'hA);
    push(4'h6, 4'h1, 4'h8);
    cmd_valid = 1'b0;
    wait_rsp();
    @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    model_cnt  = '0;
    last_legal = '0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_count", 32'(op_count), 32'd0);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    push(4'h8, 4'h9, 4'h0);
    cmd_valid = 1'b0;
    drain();

    // Random traffic: 255 more accepted ops brings the counter to 256, i.e. wrapped to 0
    pushes = 0;
    cycles = 0;
    @(posedge clk);
    #1;
    while (pushes < 255 && cycles < 20000) begin
      rsp_ready = $urandom_range(0, 3) != 0;
      cmd_valid = $urandom_range(0, 3) != 0;
      cmd_sel   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                              : 4'($urandom_range(0, 9));
      cmd_a     = 4'($urandom_range(0, 15));
      cmd_b     = 4'($urandom_range(0, 15));
      @(negedge clk);
      if (cmd_valid && cmd_ready) pushes++;
      @(posedge clk);
      #1;
      cycles++;
    end
    chk("rand_pushes", 32'(pushes), 32'd255);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    drain();
    chk("wrap_op_count", 32'(op_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
